// File: rtl/mmio_pkg.sv
// Shared definitions for the memory-mapped countdown timer: register
// offsets, CTRL bit positions, FSM states and the build-time prescaler
// switch (macro MMIO_TIMER_PRESCALE_EN).
package mmio_pkg;

    // Register select values, taken from DataAdr[3:2]
    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_LOAD   = 2'd1;
    localparam logic [1:0] REG_COUNT  = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    // CTRL and STATUS bit positions
    localparam int CTRL_EN_BIT    = 0;
    localparam int CTRL_AUTO_BIT  = 1;
    localparam int CTRL_IE_BIT    = 2;
    localparam int STATUS_EXP_BIT = 0;

    // Prescaler enable, fixed at build time
`ifdef MMIO_TIMER_PRESCALE_EN
    localparam bit PRESCALE_EN = 1'b1;
`else
    localparam bit PRESCALE_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } timer_state_e;

    typedef struct packed {
        logic ie;
        logic auto_reload;
        logic en;
    } ctrl_t;

    // Place the CTRL fields at their bus bit positions; all other bits read 0
    function automatic logic [31:0] ctrl_word(input ctrl_t c);
        logic [31:0] w;
        w = '0;
        w[CTRL_EN_BIT]   = c.en;
        w[CTRL_AUTO_BIT] = c.auto_reload;
        w[CTRL_IE_BIT]   = c.ie;
        return w;
    endfunction

endpackage

// File: rtl/mmio_prescaler.sv
// Tick divisor for the timer: tick is high once every DIV cycles after
// clr is released. With DIV = 1 the tick is high on every cycle.
module mmio_prescaler
    import mmio_pkg::*;
#(
    parameter int unsigned DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    output logic tick
);

    localparam logic [15:0] LAST = 16'(DIV - 1);

    logic [15:0] cnt_q;

    assign tick = (cnt_q == LAST);

    // Cycle counter, held at zero while clr is asserted, wraps on each tick
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (reset || clr) begin
            cnt_q <= '0;
        end else if (tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

endmodule

// File: rtl/mmio_timer.sv
// Memory-mapped countdown timer with CTRL/LOAD/COUNT/STATUS registers,
// one-shot or auto-reload operation and a level interrupt. Optional tick
// prescaling is built in when MMIO_TIMER_PRESCALE_EN is defined.
module mmio_timer
    import mmio_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0400,
    parameter int unsigned PRESCALE  = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] DataAdr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        Hit,
    output logic        Irq
);

    localparam int unsigned TICK_DIV = PRESCALE_EN ? PRESCALE : 1;

    timer_state_e state_q, state_d;
    ctrl_t        ctrl_q;
    logic [31:0]  load_q;
    logic [31:0]  count_q, count_d;
    logic         exp_q, exp_d;

    logic [1:0]   reg_sel;
    logic         wr, wr_ctrl, wr_load, wr_status;
    logic         start, stop, run_tick, expire;
    logic         tick;
    logic         unused_adr_bits;

    // Byte-lane address bits carry no meaning for word registers
    assign unused_adr_bits = ^DataAdr[1:0];

    assign Hit       = (DataAdr[31:4] == BASE_ADDR[31:4]);
    assign reg_sel   = DataAdr[3:2];
    assign wr        = MemWrite && Hit;
    assign wr_ctrl   = wr && (reg_sel == REG_CTRL);
    assign wr_load   = wr && (reg_sel == REG_LOAD);
    assign wr_status = wr && (reg_sel == REG_STATUS);

    // An EN=1 write only (re)starts a stopped timer; in RUN it just updates CTRL
    assign start = wr_ctrl && WriteData[CTRL_EN_BIT] && (state_q != RUN);
    // A disable write freezes the count and overrides any tick that cycle
    assign stop  = wr_ctrl && !WriteData[CTRL_EN_BIT];

    assign run_tick = (state_q == RUN) && tick && !stop;
    assign expire   = run_tick && (count_q == 32'd0);

    mmio_prescaler #(
        .DIV (TICK_DIV)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .clr   (state_q != RUN),
        .tick  (tick)
    );

    // Next-state, next-count and expiry flag logic
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        state_d = state_q;
        count_d = count_q;
        exp_d   = exp_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = RUN;
                    count_d = load_q;
                end
            end
            RUN: begin
                if (run_tick) begin
                    if (count_q != 32'd0) begin
                        count_d = count_q - 32'd1;
                    end else if (ctrl_q.auto_reload) begin
                        count_d = load_q;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (stop) begin
            state_d = IDLE;
            count_d = count_q;
        end

        // Expiry takes precedence over a same-cycle software clear
        if (expire) begin
            exp_d = 1'b1;
        end else if (wr_status && WriteData[STATUS_EXP_BIT]) begin
            exp_d = 1'b0;
        end
    end

    // State and register file; reset wins over any simultaneous bus write
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            ctrl_q  <= '0;
            load_q  <= '0;
            count_q <= '0;
            exp_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            exp_q   <= exp_d;
            if (wr_ctrl) begin
                ctrl_q <= '{ie:          WriteData[CTRL_IE_BIT],
                            auto_reload: WriteData[CTRL_AUTO_BIT],
                            en:          WriteData[CTRL_EN_BIT]};
            end
            if (wr_load) begin
                load_q <= WriteData;
            end
        end
    end

    // Interrupt is built only from registered state
    assign Irq = exp_q && ctrl_q.ie;

    // Combinational register readback, zero outside the window
    always_comb begin
        ReadData = '0;
        if (Hit) begin
            case (reg_sel)
                REG_CTRL:   ReadData = ctrl_word(ctrl_q);
                REG_LOAD:   ReadData = load_q;
                REG_COUNT:  ReadData = count_q;
                REG_STATUS: ReadData = {31'd0, exp_q};
                default:    ReadData = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_timer.sv
// Directed bench for mmio_timer in its default build (one tick per cycle).
module tb_mmio_timer;

    localparam logic [31:0] BASE    = 32'h0000_0400;
    localparam logic [31:0] A_CTRL  = BASE + 32'h0;
    localparam logic [31:0] A_LOAD  = BASE + 32'h4;
    localparam logic [31:0] A_COUNT = BASE + 32'h8;
    localparam logic [31:0] A_STAT  = BASE + 32'hC;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemWrite;
    logic [31:0] DataAdr;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic        Hit;
    logic        Irq;

    typedef enum {OBS_RD, OBS_IRQ, OBS_HIT} obs_e;
    typedef struct {
        string       tag;
        obs_e        what;
        logic [31:0] addr;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_total = 0;
    int   n_pass  = 0;

    mmio_timer #(
        .BASE_ADDR (BASE),
        .PRESCALE  (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .MemWrite  (MemWrite),
        .DataAdr   (DataAdr),
        .WriteData (WriteData),
        .ReadData  (ReadData),
        .Hit       (Hit),
        .Irq       (Irq)
    );

    always #5 clk = ~clk;

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        MemWrite  = 1'b1;
        DataAdr   = a;
        WriteData = d;
        cycle();
        MemWrite  = 1'b0;
        WriteData = '0;
    endtask

    task automatic expect_obs(input string tag, input obs_e what,
                              input logic [31:0] addr, input logic [31:0] val);
        exp_t e;
        e.tag  = tag;
        e.what = what;
        e.addr = addr;
        e.val  = val;
        sb.push_back(e);
    endtask

    task automatic check_one();
        exp_t        e;
        logic [31:0] obs;
        n_total++;
        if (sb.size() == 0) begin
            $error("FAIL scoreboard_empty: observed 0 entries required 1");
            return;
        end
        e = sb.pop_front();
        DataAdr = e.addr;
        #1;
        case (e.what)
            OBS_RD:  obs = ReadData;
            OBS_IRQ: obs = {31'd0, Irq};
            default: obs = {31'd0, Hit};
        endcase
        assert (obs === e.val) n_pass++;
        else $error("FAIL %s: observed %h required %h", e.tag, obs, e.val);
    endtask

    task automatic check_all();
        while (sb.size() > 0) check_one();
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: observed timeout required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c1 [6] = '{3, 2, 1, 0, 0, 0};
        int c2 [7] = '{2, 1, 0, 2, 1, 0, 2};
        int i2 [7] = '{0, 0, 0, 1, 1, 1, 1};

        // Reset with a competing CTRL write: reset must win
        reset     = 1'b1;
        MemWrite  = 1'b1;
        DataAdr   = A_CTRL;
        WriteData = 32'h7;
        cycle();
        cycle();
        MemWrite  = 1'b0;
        WriteData = '0;
        cycle();
        reset = 1'b0;
        expect_obs("reset_ctrl",   OBS_RD,  A_CTRL,  32'h0);
        expect_obs("reset_load",   OBS_RD,  A_LOAD,  32'h0);
        expect_obs("reset_count",  OBS_RD,  A_COUNT, 32'h0);
        expect_obs("reset_status", OBS_RD,  A_STAT,  32'h0);
        expect_obs("reset_irq",    OBS_IRQ, A_CTRL,  32'h0);
        expect_obs("hit_base",     OBS_HIT, A_CTRL,  32'h1);
        check_all();

        // One-shot: LOAD=3, EN=1 -> 3,2,1,0 then EXP, DONE, COUNT held at 0
        bus_write(A_LOAD, 32'd3);
        expect_obs("load_rd",    OBS_RD, A_LOAD,  32'd3);
        expect_obs("idle_count", OBS_RD, A_COUNT, 32'd0);
        check_all();
        bus_write(A_CTRL, 32'h1);
        foreach (c1[i]) expect_obs("oneshot_count", OBS_RD, A_COUNT, 32'(c1[i]));
        for (int i = 0; i < 6; i++) begin
            check_one();
            if (i < 5) cycle();
        end
        expect_obs("oneshot_exp", OBS_RD,  A_STAT, 32'h1);
        expect_obs("oneshot_irq", OBS_IRQ, A_STAT, 32'h0);
        check_all();

        // Re-enable from DONE reloads; disable freezes the count
        bus_write(A_CTRL, 32'h1);
        expect_obs("rearm_count", OBS_RD, A_COUNT, 32'd3);
        check_all();
        cycle();
        expect_obs("rearm_dec", OBS_RD, A_COUNT, 32'd2);
        check_all();
        bus_write(A_CTRL, 32'h0);
        expect_obs("stop_count", OBS_RD, A_COUNT, 32'd2);
        expect_obs("stop_ctrl",  OBS_RD, A_CTRL,  32'h0);
        check_all();
        cycle();
        expect_obs("idle_hold", OBS_RD, A_COUNT, 32'd2);
        expect_obs("exp_kept",  OBS_RD, A_STAT,  32'h1);
        check_all();
        bus_write(A_STAT, 32'h1);
        expect_obs("exp_clear", OBS_RD, A_STAT, 32'h0);
        check_all();

        // Auto-reload with interrupt: LOAD=2, CTRL=7
        bus_write(A_LOAD, 32'd2);
        bus_write(A_CTRL, 32'h7);
        expect_obs("ctrl_rd", OBS_RD, A_CTRL, 32'h7);
        check_all();
        for (int i = 0; i < 7; i++) begin
            expect_obs("auto_count", OBS_RD,  A_COUNT, 32'(c2[i]));
            expect_obs("auto_irq",   OBS_IRQ, A_COUNT, 32'(i2[i]));
        end
        for (int i = 0; i < 7; i++) begin
            check_one();
            check_one();
            if (i < 6) cycle();
        end
        bus_write(A_STAT, 32'h1);
        expect_obs("clr_count", OBS_RD,  A_COUNT, 32'd1);
        expect_obs("clr_irq",   OBS_IRQ, A_COUNT, 32'h0);
        check_all();
        cycle();
        expect_obs("pre_exp_count", OBS_RD,  A_COUNT, 32'd0);
        expect_obs("pre_exp_irq",   OBS_IRQ, A_COUNT, 32'h0);
        check_all();
        bus_write(A_STAT, 32'h1);
        expect_obs("setwins_irq",   OBS_IRQ, A_STAT,  32'h1);
        expect_obs("setwins_stat",  OBS_RD,  A_STAT,  32'h1);
        expect_obs("setwins_count", OBS_RD,  A_COUNT, 32'd2);
        check_all();

        // COUNT is read-only
        bus_write(A_COUNT, 32'hFFFF_FFFF);
        expect_obs("count_ro", OBS_RD, A_COUNT, 32'd1);
        check_all();

        // LOAD written mid-run only applies at the next reload
        bus_write(A_LOAD, 32'd5);
        expect_obs("load_mid_count", OBS_RD, A_COUNT, 32'd0);
        expect_obs("load_mid_rd",    OBS_RD, A_LOAD,  32'd5);
        check_all();

        // Out-of-window address and ignored byte-lane bits
        expect_obs("miss_hit",   OBS_HIT, BASE + 32'h10, 32'h0);
        expect_obs("miss_rd",    OBS_RD,  BASE + 32'h10, 32'h0);
        expect_obs("lowbits_rd", OBS_RD,  BASE + 32'h5,  32'd5);
        check_all();
        bus_write(BASE + 32'h10, 32'h0);
        expect_obs("miss_ctrl",   OBS_RD,  A_CTRL,  32'h7);
        expect_obs("miss_load",   OBS_RD,  A_LOAD,  32'd5);
        expect_obs("reload_new",  OBS_RD,  A_COUNT, 32'd5);
        expect_obs("reload_irq",  OBS_IRQ, A_COUNT, 32'h1);
        check_all();

        // LOAD=0 with AUTO: expiry on every tick beats back-to-back clears
        bus_write(A_CTRL, 32'h0);
        expect_obs("stop2_count", OBS_RD, A_COUNT, 32'd5);
        check_all();
        bus_write(A_STAT, 32'h1);
        bus_write(A_LOAD, 32'd0);
        bus_write(A_CTRL, 32'h3);
        expect_obs("zero_start_count", OBS_RD, A_COUNT, 32'd0);
        expect_obs("zero_start_exp",   OBS_RD, A_STAT,  32'h0);
        check_all();
        bus_write(A_STAT, 32'h1);
        expect_obs("zero_exp_1",   OBS_RD, A_STAT,  32'h1);
        expect_obs("zero_count_1", OBS_RD, A_COUNT, 32'd0);
        check_all();
        bus_write(A_STAT, 32'h1);
        expect_obs("zero_exp_2", OBS_RD, A_STAT, 32'h1);
        check_all();

        // Reset mid-run at COUNT=5 with Irq high
        bus_write(A_CTRL, 32'h0);
        bus_write(A_LOAD, 32'd9);
        bus_write(A_CTRL, 32'h5);
        repeat (4) cycle();
        expect_obs("mid_count", OBS_RD,  A_COUNT, 32'd5);
        expect_obs("mid_irq",   OBS_IRQ, A_COUNT, 32'h1);
        check_all();
        reset = 1'b1;
        expect_obs("sync_reset_hold", OBS_RD, A_COUNT, 32'd5);
        check_all();
        cycle();
        reset = 1'b0;
        expect_obs("rst_ctrl",   OBS_RD,  A_CTRL,  32'h0);
        expect_obs("rst_load",   OBS_RD,  A_LOAD,  32'h0);
        expect_obs("rst_count",  OBS_RD,  A_COUNT, 32'h0);
        expect_obs("rst_status", OBS_RD,  A_STAT,  32'h0);
        expect_obs("rst_irq",    OBS_IRQ, A_STAT,  32'h0);
        check_all();

        // After reset the timer is idle: a LOAD write does not start counting
        bus_write(A_LOAD, 32'd4);
        cycle();
        expect_obs("post_rst_idle", OBS_RD, A_COUNT, 32'h0);
        check_all();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mmio_timer.md
MMIO_TIMER -- requirements
Module: mmio_timer

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0000_0400: 16-byte aligned base of the register window.
REQ-002 SHALL have parameter PRESCALE, default 4: tick divisor, legal range 1..65535, used only with MMIO_TIMER_PRESCALE_EN.
REQ-003 SHALL have port clk, input, 1: sole clock.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port MemWrite, input, 1: processor store strobe.
REQ-006 SHALL have port DataAdr, input, 32: processor data address.
REQ-007 SHALL have port WriteData, input, 32: processor store data.
REQ-008 SHALL have port ReadData, output, 32: combinational register readback.
REQ-009 SHALL have port Hit, output, 1: DataAdr lies in the register window.
REQ-010 SHALL have port Irq, output, 1: interrupt request.

Function
REQ-011 SHALL assert Hit when DataAdr[31:4] == BASE_ADDR[31:4]; DataAdr[1:0] ignored.
REQ-012 SHALL decode DataAdr[3:2] to these registers:
- 0 CTRL, RW: bit0 EN, bit1 AUTO, bit2 IE; other bits read 0.
- 1 LOAD, RW, 32 bits.
- 2 COUNT, RO; writes ignored.
- 3 STATUS: bit0 EXP; a write of 1 to bit0 clears EXP.
REQ-013 SHALL capture register writes on the clk edge where MemWrite && Hit; no write effect when Hit=0.
REQ-014 SHALL drive ReadData combinationally with the addressed register when Hit=1, else 32'h0.
REQ-015 SHALL implement FSM states IDLE, RUN, DONE.
REQ-016 Transitions, all taking effect the following cycle:
- IDLE to RUN when EN is written 1; COUNT loads LOAD.
- Any state to IDLE when EN is written 0; COUNT holds.
- DONE to RUN when EN is rewritten 1; COUNT reloads.
REQ-017 In RUN, on each tick:
- COUNT != 0: COUNT decrements by 1.
- COUNT == 0: EXP is set; with AUTO=1, COUNT reloads LOAD and the FSM stays in RUN; with AUTO=0, the FSM goes to DONE and COUNT holds 0.
REQ-018 SHALL treat a LOAD write during RUN as taking effect only at the next reload; the current COUNT is unaffected.
REQ-019 With LOAD=0 and AUTO=1, SHALL set EXP on every tick.
REQ-020 If an EXP clear write and an expiry occur in the same cycle, SHALL leave EXP set (set wins).
REQ-021 SHALL drive Irq = EXP && IE from registered state, with no combinational path from the bus inputs.
REQ-022 SHALL count with unsigned 32-bit arithmetic and SHALL never decrement below 0.

Reset
REQ-023 On reset=1 at a clk edge, SHALL set state IDLE, CTRL=0, LOAD=0, COUNT=0, EXP=0 and prescaler=0.
REQ-024 SHALL give reset priority over a simultaneous bus write.
REQ-025 Reset while in RUN SHALL abort the count with no EXP set; Irq=0 in the next cycle.

Configuration
REQ-026 With macro MMIO_TIMER_PRESCALE_EN defined, SHALL produce a tick once every PRESCALE clk cycles while in RUN; the prescaler clears on entry to RUN.
REQ-027 Without MMIO_TIMER_PRESCALE_EN, SHALL produce a tick every clk cycle in RUN; the PRESCALE parameter is unused.

Structure
REQ-028 SHALL take register offsets, CTRL bit positions and the FSM state enum from shared package mmio_pkg.
REQ-029 SHALL place the prescaler in sub-module mmio_prescaler, which has inputs clk, reset, clr and output tick.

Verification
REQ-030 Without the macro: LOAD=3 then CTRL=1 gives COUNT 3,2,1,0 on successive cycles, then EXP=1, state DONE, COUNT stays 0.
REQ-031 CTRL=7 with LOAD=2 gives COUNT 2,1,0,2,1,0 and Irq=1 from the first expiry; a STATUS write of 1 drops Irq the next cycle unless an expiry coincides.
REQ-032 An EXP clear written in the same cycle as an expiry leaves EXP=1; ReadData at BASE+0xC reads 32'h1.
REQ-033 A write of 32'hFFFF_FFFF to BASE+0x8 leaves COUNT unchanged; a write to BASE+0x10 gives Hit=0, no register change, ReadData=0.
REQ-034 With the macro and PRESCALE=4, LOAD=1 and CTRL=1: COUNT goes 1 to 0 after 4 cycles and EXP sets 4 cycles later.
REQ-035 Reset asserted mid-RUN with COUNT=5 gives all registers 0, state IDLE and Irq=0 on the next cycle.
